// File: rtl/moving_ave_pkg.sv
// Shared widths and types for the moving-average filter.
// SUM_W is wide enough to hold TAPS full-scale samples without wrapping.
package moving_ave_pkg;

  localparam int DATA_W    = 16;
  localparam int TAPS      = 128;
  localparam int LOG2_TAPS = $clog2(TAPS);
  localparam int SUM_W     = DATA_W + LOG2_TAPS;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [SUM_W-1:0]  sum_t;
  typedef logic [LOG2_TAPS-1:0]     ptr_t;

endpackage

// File: rtl/moving_ave_delay_line.sv
// Circular window of the last TAPS samples; old_dat is the entry about to be
// overwritten, so the caller evicts and writes in the same cycle.
module moving_ave_delay_line
  import moving_ave_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_dat,
  output logic [DATA_W-1:0] old_dat
);

  ptr_t              ptr;
  logic [DATA_W-1:0] mem [TAPS];

  assign old_dat = mem[ptr];

  // Flop-based storage so the whole window clears in a single reset cycle.
  always_ff @(posedge clk) begin
    if (clr) begin
      ptr <= '0;
      for (int i = 0; i < TAPS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[ptr] <= wr_dat;
      ptr      <= ptr + ptr_t'(1);
    end
  end

endmodule

// File: rtl/moving_ave.sv
// Streaming moving average over TAPS samples, one output per accepted input, 1-cycle latency.
// Define MOVING_AVE_ROUND_EN for round-half-up output; default build floors.
module moving_ave
  import moving_ave_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  output logic              ASI_READY,
  input  logic              ASI_VALID,
  input  logic [DATA_W-1:0] ASI_DATA,
  output logic              ASO_VALID,
  output logic [DATA_W-1:0] ASO_DATA,
  output logic              ASO_ERROR
);

  logic              ready_q;
  logic              accept;
  logic [DATA_W-1:0] old_dat;
  sum_t              sum;
  sum_t              sum_nxt;
  sample_t           avg;

  // Ready drops combinationally with RESET so the reset cycle itself refuses input.
  assign ASI_READY = ready_q & ~RESET;
  assign accept    = ASI_VALID & ASI_READY;

  moving_ave_delay_line u_delay_line (
    .clk     (CLK),
    .clr     (RESET),
    .wr_en   (accept),
    .wr_dat  (ASI_DATA),
    .old_dat (old_dat)
  );

  assign sum_nxt = sum + sum_t'($signed(ASI_DATA)) - sum_t'($signed(old_dat));

`ifdef MOVING_AVE_ROUND_EN
  logic signed [SUM_W:0] rnd_sum;

  assign rnd_sum = {sum_nxt[SUM_W-1], sum_nxt} + (SUM_W+1)'(TAPS / 2);

  // Top two bits of the shifted value at 01 means it exceeds the positive range.
  always_comb begin
    avg = rnd_sum[DATA_W-1+LOG2_TAPS:LOG2_TAPS];
    if (!rnd_sum[SUM_W] && rnd_sum[SUM_W-1]) begin
      avg = {1'b0, {(DATA_W-1){1'b1}}};
    end
  end
`else
  assign avg = sum_nxt[SUM_W-1:LOG2_TAPS];
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ready_q   <= 1'b0;
      sum       <= '0;
      ASO_VALID <= 1'b0;
      ASO_DATA  <= '0;
      ASO_ERROR <= 1'b0;
    end else begin
      ready_q   <= 1'b1;
      ASO_VALID <= accept;
      ASO_ERROR <= ASI_VALID & ~ASI_READY;
      if (accept) begin
        sum      <= sum_nxt;
        ASO_DATA <= avg;
      end
    end
  end

endmodule

// File: tb/tb_moving_ave.sv
// Directed and random stimulus for moving_ave against a window-resumming model.
module tb_moving_ave;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        ASI_READY;
  logic        ASI_VALID;
  logic [15:0] ASI_DATA;
  logic        ASO_VALID;
  logic [15:0] ASO_DATA;
  logic        ASO_ERROR;

  int n_pass  = 0;
  int n_total = 0;
  int win [128];
  int widx;

  always #5 CLK = ~CLK;

  moving_ave dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .ASI_READY (ASI_READY),
    .ASI_VALID (ASI_VALID),
    .ASI_DATA  (ASI_DATA),
    .ASO_VALID (ASO_VALID),
    .ASO_DATA  (ASO_DATA),
    .ASO_ERROR (ASO_ERROR)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 128; i++) win[i] = 0;
    widx = 0;
  endfunction

  function automatic logic [15:0] model_push(input logic [15:0] s);
    int acc;
    int q;
    win[widx] = int'($signed(s));
    widx = (widx + 1) % 128;
    acc = 0;
    for (int i = 0; i < 128; i++) acc += win[i];
`ifdef MOVING_AVE_ROUND_EN
    q = (acc + 64) >>> 7;
    if (q > 32767) q = 32767;
`else
    q = acc >>> 7;
`endif
    return q[15:0];
  endfunction

  task automatic step(input logic v, input logic [15:0] d);
    ASI_VALID = v;
    ASI_DATA  = d;
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input string tag, input logic [15:0] d, input logic [15:0] exp);
    step(1'b1, d);
    check({tag, "_vld"}, {15'd0, ASO_VALID}, 16'd1);
    check(tag, ASO_DATA, exp);
  endtask

  initial begin
    logic [15:0] e;
    logic [15:0] s;
    logic [15:0] ramp_first;
`ifdef MOVING_AVE_ROUND_EN
    ramp_first = 16'h0100;
`else
    ramp_first = 16'h00FF;
`endif
    RESET     = 1'b1;
    ASI_VALID = 1'b0;
    ASI_DATA  = 16'h0000;
    model_clear();
    repeat (3) @(posedge CLK);
    #1;
    check("rst_ready", {15'd0, ASI_READY}, 16'd0);
    check("rst_valid", {15'd0, ASO_VALID}, 16'd0);
    check("rst_data",  ASO_DATA, 16'h0000);
    check("rst_error", {15'd0, ASO_ERROR}, 16'd0);

    // First cycle after reset release: still not ready; a sample here is an error.
    RESET = 1'b0;
    #1;
    check("ready_low_after_rst", {15'd0, ASI_READY}, 16'd0);
    step(1'b1, 16'h1234);
    check("err_pulse", {15'd0, ASO_ERROR}, 16'd1);
    check("err_no_valid", {15'd0, ASO_VALID}, 16'd0);
    check("ready_high", {15'd0, ASI_READY}, 16'd1);
    step(1'b0, 16'h0000);
    check("err_one_cycle", {15'd0, ASO_ERROR}, 16'd0);
    check("idle_no_valid", {15'd0, ASO_VALID}, 16'd0);

    // Full-scale positive ramp; the first output proves the dropped sample is absent.
    for (int k = 1; k <= 128; k++) begin
      e = model_push(16'h7FFF);
      push("ramp", 16'h7FFF, e);
      if (k == 1) check("ramp_first", ASO_DATA, ramp_first);
    end
    check("ramp_128", ASO_DATA, 16'h7FFF);
    for (int k = 0; k < 10; k++) begin
      void'(model_push(16'h7FFF));
      push("steady_pos", 16'h7FFF, 16'h7FFF);
    end
    step(1'b0, 16'h0000);
    check("hold_no_valid", {15'd0, ASO_VALID}, 16'd0);
    check("hold_data", ASO_DATA, 16'h7FFF);

    for (int k = 0; k < 128; k++) push("flush", 16'h0000, model_push(16'h0000));
    check("flush_zero", ASO_DATA, 16'h0000);

    // Impulse of 128 stays at 1 for exactly one window.
    void'(model_push(16'h0080));
    push("imp_1", 16'h0080, 16'h0001);
    for (int k = 2; k <= 128; k++) begin
      void'(model_push(16'h0000));
      push("imp", 16'h0000, 16'h0001);
    end
    void'(model_push(16'h0000));
    push("imp_129", 16'h0000, 16'h0000);

    for (int k = 1; k <= 128; k++) begin
      e = model_push(16'h8000);
      push("neg", 16'h8000, e);
      if (k == 1) check("neg_first", ASO_DATA, 16'hFF00);
    end
    check("neg_final", ASO_DATA, 16'h8000);

    // Mid-stream reset: ready low for the reset cycle and the one after.
    for (int k = 0; k < 50; k++) push("pre_rst", 16'h1000, model_push(16'h1000));
    RESET     = 1'b1;
    ASI_VALID = 1'b0;
    #1;
    check("mid_rst_ready0", {15'd0, ASI_READY}, 16'd0);
    @(posedge CLK);
    #1;
    check("mid_rst_valid", {15'd0, ASO_VALID}, 16'd0);
    check("mid_rst_data",  ASO_DATA, 16'h0000);
    check("mid_rst_error", {15'd0, ASO_ERROR}, 16'd0);
    RESET = 1'b0;
    #1;
    check("mid_rst_ready1", {15'd0, ASI_READY}, 16'd0);
    @(posedge CLK);
    #1;
    check("mid_rst_ready2", {15'd0, ASI_READY}, 16'd1);
    model_clear();
    void'(model_push(16'h1000));
    push("post_rst", 16'h1000, 16'h0020);

    // Random stream from a clean window.
    RESET = 1'b1;
    step(1'b0, 16'h0000);
    RESET = 1'b0;
    step(1'b0, 16'h0000);
    model_clear();
    for (int k = 0; k < 1024; k++) begin
      s = 16'($urandom);
      push("rand", s, model_push(s));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
